// File: rtl/sensor_switch_ctrl_pkg.sv
// Shared definitions for the sensor-driven switch controller: mode codes,
// channel state encoding and width helpers.
package sensor_switch_ctrl_pkg;

    localparam logic [1:0] MODE_AUTO      = 2'b00;
    localparam logic [1:0] MODE_FORCE_ON  = 2'b01;
    localparam logic [1:0] MODE_FORCE_OFF = 2'b10;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StArm  = 2'b01,
        StOn   = 2'b10,
        StHold = 2'b11
    } ch_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ssc_channel.sv
// Single sensor channel: debounce on rising sensor, off-delay with retrigger on falling sensor.
// o_sw is the switch decode of the next state; the top level registers it.
module ssc_channel
    import sensor_switch_ctrl_pkg::*;
#(
    parameter int unsigned DB_CYC   = 3,
    parameter int unsigned HOLD_CYC = 50
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sensor,
    input  logic i_auto_en,
    output logic o_sw
);

    localparam int unsigned CW = clog2(max2(DB_CYC, HOLD_CYC) + 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);

    ch_state_e     r_state;
    ch_state_e     w_state_d;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        if (!i_auto_en) begin
            // Forced modes park the channel so AUTO always restarts a full debounce.
            w_state_d = StIdle;
            w_cnt_d   = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_sensor) begin
                        if (DB_CYC == 1) begin
                            w_state_d = StOn;
                            w_cnt_d   = '0;
                        end else begin
                            w_state_d = StArm;
                            w_cnt_d   = CW'(1);
                        end
                    end
                end
                StArm: begin
                    if (!i_sensor) begin
                        w_state_d = StIdle;
                        w_cnt_d   = '0;
                    end else if (r_cnt == DB_LAST) begin
                        w_state_d = StOn;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = r_cnt + CW'(1);
                    end
                end
                StOn: begin
                    if (!i_sensor) begin
                        if (HOLD_CYC == 1) begin
                            w_state_d = StIdle;
                            w_cnt_d   = '0;
                        end else begin
                            w_state_d = StHold;
                            w_cnt_d   = CW'(1);
                        end
                    end
                end
                StHold: begin
                    if (i_sensor) begin
                        w_state_d = StOn;
                        w_cnt_d   = '0;
                    end else if (r_cnt == HOLD_LAST) begin
                        w_state_d = StIdle;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = r_cnt + CW'(1);
                    end
                end
                default: begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end
            endcase
        end
    end

    assign o_sw = (w_state_d == StOn) || (w_state_d == StHold);

endmodule

// File: rtl/sensor_switch_ctrl.sv
// N-channel sensor-driven switch controller with global force modes, registered
// popcount of active switches and a saturating switch-on usage accumulator.
module sensor_switch_ctrl
    import sensor_switch_ctrl_pkg::*;
#(
    parameter int unsigned N_CH     = 3,
    parameter int unsigned DB_CYC   = 3,
    parameter int unsigned HOLD_CYC = 50,
    parameter int unsigned G_W      = 32
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [N_CH-1:0]              i_sensor,
    input  logic [1:0]                   i_mode,
    input  logic                         i_g_clr,
    output logic [N_CH-1:0]              o_switch,
    output logic [clog2(N_CH+1)-1:0]     o_n_on,
    output logic [G_W-1:0]               o_g
);

    localparam int unsigned NW = clog2(N_CH + 1);

    logic            w_force_on;
    logic            w_force_off;
    logic            w_auto_en;
    logic [N_CH-1:0] w_sw_auto;
    logic [N_CH-1:0] w_switch_d;
    logic [NW-1:0]   w_pop;
    logic [G_W:0]    w_g_sum;
    logic [G_W-1:0]  w_g_d;

    logic [N_CH-1:0] r_switch;
    logic [NW-1:0]   r_n_on;
    logic [G_W-1:0]  r_g;

    // Mode 11 falls through to AUTO because it matches neither force code.
    assign w_force_on  = (i_mode == MODE_FORCE_ON);
    assign w_force_off = (i_mode == MODE_FORCE_OFF);
    assign w_auto_en   = !(w_force_on || w_force_off);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ssc_channel #(
            .DB_CYC   (DB_CYC),
            .HOLD_CYC (HOLD_CYC)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_sensor  (i_sensor[i]),
            .i_auto_en (w_auto_en),
            .o_sw      (w_sw_auto[i])
        );
    end

    always_comb begin
        w_switch_d = w_sw_auto;
        if (w_force_on) begin
            w_switch_d = '1;
        end else if (w_force_off) begin
            w_switch_d = '0;
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_pop = w_pop + NW'(w_switch_d[i]);
        end
    end

    // Extra carry bit detects overflow so g pins at all-ones instead of wrapping.
    assign w_g_sum = {1'b0, r_g} + (G_W + 1)'(r_n_on);

    always_comb begin
        w_g_d = w_g_sum[G_W-1:0];
        if (i_g_clr) begin
            w_g_d = '0;
        end else if (w_g_sum[G_W]) begin
            w_g_d = '1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_switch <= '0;
            r_n_on   <= '0;
            r_g      <= '0;
        end else begin
            r_switch <= w_switch_d;
            r_n_on   <= w_pop;
            r_g      <= w_g_d;
        end
    end

    assign o_switch = r_switch;
    assign o_n_on   = r_n_on;
    assign o_g      = r_g;

endmodule

// File: tb/tb_sensor_switch_ctrl.sv
// Directed bench for sensor_switch_ctrl: a 32-bit-counter instance for channel behaviour
// and a 4-bit-counter instance sharing the same stimulus for saturation.
module tb_sensor_switch_ctrl;

    logic        clk;
    logic        rst;
    logic [2:0]  sensor;
    logic [1:0]  mode;
    logic        g_clr;
    logic [2:0]  switch_m;
    logic [1:0]  n_on_m;
    logic [31:0] g_m;
    logic [2:0]  switch_s;
    logic [1:0]  n_on_s;
    logic [3:0]  g_s;

    int n_checks;
    int n_fail;

    sensor_switch_ctrl #(
        .N_CH(3), .DB_CYC(3), .HOLD_CYC(5), .G_W(32)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_sensor(sensor), .i_mode(mode), .i_g_clr(g_clr),
        .o_switch(switch_m), .o_n_on(n_on_m), .o_g(g_m)
    );

    sensor_switch_ctrl #(
        .N_CH(3), .DB_CYC(3), .HOLD_CYC(5), .G_W(4)
    ) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_sensor(sensor), .i_mode(mode), .i_g_clr(g_clr),
        .o_switch(switch_s), .o_n_on(n_on_s), .o_g(g_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        sensor = 3'b000;
        mode   = 2'b00;
        g_clr  = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [2:0] exp_sw [3];
        exp_sw[0] = 3'b000;
        exp_sw[1] = 3'b000;
        exp_sw[2] = 3'b111;
        rst    = 1'b1;
        sensor = 3'b111;
        mode   = 2'b00;
        g_clr  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (switch_m !== 3'b000 || g_m !== 32'd0 || n_on_m !== 2'd0) begin
                $display("FAIL reset_hold[%0d]: switch=%b g=%0d n_on=%0d, want 000/0/0",
                         i, switch_m, g_m, n_on_m);
                n_fail++;
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (switch_m !== exp_sw[i]) begin
                $display("FAIL reset_release[%0d]: switch=%b, want %b", i, switch_m, exp_sw[i]);
                n_fail++;
            end
        end
        n_checks++;
        if (n_on_m !== 2'd3 || g_m !== 32'd0) begin
            $display("FAIL reset_first_on: n_on=%0d g=%0d, want 3/0", n_on_m, g_m);
            n_fail++;
        end
        tick();
        n_checks++;
        if (g_m !== 32'd3) begin
            $display("FAIL reset_g_first_add: g=%0d, want 3", g_m);
            n_fail++;
        end
    endtask

    task automatic test_debounce();
        logic       pat [6];
        logic [2:0] exp_sw [6];
        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_sw = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            sensor = {2'b00, pat[i]};
            tick();
            n_checks++;
            if (switch_m !== exp_sw[i]) begin
                $display("FAIL debounce[%0d]: switch=%b, want %b", i, switch_m, exp_sw[i]);
                n_fail++;
            end
        end
    endtask

    task automatic test_hold_retrigger();
        logic       pat [10];
        logic [2:0] exp_sw [10];
        do_reset();
        sensor = 3'b010;
        tick();
        tick();
        tick();
        n_checks++;
        if (switch_m !== 3'b010) begin
            $display("FAIL hold_on: switch=%b, want 010", switch_m);
            n_fail++;
        end
        pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_sw = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010,
                   3'b010, 3'b010, 3'b010, 3'b010, 3'b000};
        for (int i = 0; i < 10; i++) begin
            sensor = {1'b0, pat[i], 1'b0};
            tick();
            n_checks++;
            if (switch_m !== exp_sw[i]) begin
                $display("FAIL hold[%0d]: switch=%b, want %b", i, switch_m, exp_sw[i]);
                n_fail++;
            end
        end
    endtask

    task automatic test_independence();
        do_reset();
        sensor = 3'b101;
        tick();
        tick();
        n_checks++;
        if (switch_m !== 3'b000) begin
            $display("FAIL indep_pre: switch=%b, want 000", switch_m);
            n_fail++;
        end
        tick();
        n_checks++;
        if (switch_m !== 3'b101 || n_on_m !== 2'd2 || g_m !== 32'd0) begin
            $display("FAIL indep_on: switch=%b n_on=%0d g=%0d, want 101/2/0",
                     switch_m, n_on_m, g_m);
            n_fail++;
        end
        tick();
        n_checks++;
        if (g_m !== 32'd2) begin
            $display("FAIL indep_g1: g=%0d, want 2", g_m);
            n_fail++;
        end
        tick();
        n_checks++;
        if (g_m !== 32'd4) begin
            $display("FAIL indep_g2: g=%0d, want 4", g_m);
            n_fail++;
        end
    endtask

    task automatic test_modes();
        logic [2:0] exp_sw [3];
        exp_sw = '{3'b000, 3'b000, 3'b010};
        do_reset();
        sensor = 3'b010;
        tick();
        tick();
        tick();
        mode = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (switch_m !== 3'b000 || n_on_m !== 2'd0) begin
                $display("FAIL force_off[%0d]: switch=%b n_on=%0d, want 000/0",
                         i, switch_m, n_on_m);
                n_fail++;
            end
        end
        mode = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (switch_m !== exp_sw[i]) begin
                $display("FAIL auto_return[%0d]: switch=%b, want %b", i, switch_m, exp_sw[i]);
                n_fail++;
            end
        end
        sensor = 3'b000;
        mode   = 2'b01;
        tick();
        n_checks++;
        if (switch_m !== 3'b111 || n_on_m !== 2'd3) begin
            $display("FAIL force_on: switch=%b n_on=%0d, want 111/3", switch_m, n_on_m);
            n_fail++;
        end
        // Mode 11 behaves as AUTO: channels sit in IDLE with sensors low.
        mode = 2'b11;
        tick();
        n_checks++;
        if (switch_m !== 3'b000 || n_on_m !== 2'd0) begin
            $display("FAIL mode11_auto: switch=%b n_on=%0d, want 000/0", switch_m, n_on_m);
            n_fail++;
        end
        sensor = 3'b100;
        tick();
        tick();
        tick();
        n_checks++;
        if (switch_m !== 3'b100) begin
            $display("FAIL mode11_debounce: switch=%b, want 100", switch_m);
            n_fail++;
        end
    endtask

    task automatic test_saturation_clear();
        logic [3:0] exp_g [7];
        exp_g = '{4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd15};
        do_reset();
        mode = 2'b01;
        for (int i = 0; i < 7; i++) begin
            tick();
            n_checks++;
            if (g_s !== exp_g[i]) begin
                $display("FAIL sat_g[%0d]: g=%0d, want %0d", i, g_s, exp_g[i]);
                n_fail++;
            end
        end
        n_checks++;
        if (g_m !== 32'd18) begin
            $display("FAIL wide_g_no_sat: g=%0d, want 18", g_m);
            n_fail++;
        end
        g_clr = 1'b1;
        tick();
        n_checks++;
        if (g_s !== 4'd0 || g_m !== 32'd0 || n_on_s !== 2'd3) begin
            $display("FAIL g_clr: g_sat=%0d g_wide=%0d n_on=%0d, want 0/0/3",
                     g_s, g_m, n_on_s);
            n_fail++;
        end
        g_clr = 1'b0;
        tick();
        n_checks++;
        if (g_s !== 4'd3) begin
            $display("FAIL g_after_clr: g=%0d, want 3", g_s);
            n_fail++;
        end
        mode = 2'b00;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        sensor   = 3'b000;
        mode     = 2'b00;
        g_clr    = 1'b0;
        test_reset();
        test_debounce();
        test_hold_retrigger();
        test_independence();
        test_modes();
        test_saturation_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sensor_switch_ctrl.md
Name: sensor_switch_ctrl

Overview:
Parametrised N-channel sensor-driven switch controller, generalising the fixed three-sensor/three-switch controller. Each channel debounces its sensor, turns its switch on, holds it on for a programmable off-delay after the sensor drops, and re-triggers if the sensor returns during hold. A global mode input can force all switches on or off. A saturating usage counter accumulates switch-on channel-cycles for display.

Parameters:
N_CH, 3, number of sensor/switch channels (1..16)
DB_CYC, 3, consecutive high samples needed to turn a switch on (>=1)
HOLD_CYC, 50, consecutive low samples needed to turn a switch off (>=1; 50 = 5 s at 100 ms clk)
G_W, 32, width of usage counter g

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset
sensor  in  N_CH  raw sensor levels, bit i = channel i; synchronous to clk
mode  in  2  00 AUTO, 01 FORCE_ON, 10 FORCE_OFF, 11 treated as AUTO
g_clr  in  1  synchronous clear of g
switch  out  N_CH  switch drive, bit i = channel i, registered
n_on  out  clog2(N_CH+1)  popcount of switch, registered
g  out  G_W  saturating usage counter, registered

Behaviour:
- Reset: one clock and one reset; reset is synchronous and active-high. With rst=1 at a rising edge: every channel FSM goes to IDLE and its counter goes to 0; switch=0, n_on=0, g=0. rst has priority over everything, including mid-debounce and mid-hold.
- Per-channel FSM, AUTO mode, evaluated at each rising edge on the sampled sensor[i]:
  IDLE (sw=0): sensor=1 -> ARM with cnt=1. If DB_CYC=1, go directly to ON instead.
  ARM (sw=0): sensor=0 -> IDLE, cnt=0. sensor=1 and cnt==DB_CYC-1 -> ON. Otherwise cnt++.
  ON (sw=1): sensor=0 -> HOLD with cnt=1. If HOLD_CYC=1, go directly to IDLE instead.
  HOLD (sw=1): sensor=1 -> ON (retrigger), cnt=0. sensor=0 and cnt==HOLD_CYC-1 -> IDLE. Otherwise cnt++.
- Latency:
  - switch[i] rises at the edge that takes the DB_CYC-th consecutive high sample.
  - switch[i] falls at the edge that takes the HOLD_CYC-th consecutive low sample.
- switch[i] is a registered decode of the next state: 1 in ON or HOLD.
- Channels are fully independent. Simultaneous events on several channels are each handled in the same cycle.
- Counter width is clog2(max(DB_CYC,HOLD_CYC)+1). Counters never wrap.
- FORCE_ON / FORCE_OFF:
  - All channel FSMs are held in IDLE with cnt=0.
  - switch becomes all-ones or all-zeros respectively at the next edge.
- Returning to AUTO: all channels start from IDLE. A sensor that is already high must complete the full DB_CYC debounce, so the switch drops for at least DB_CYC-1 cycles when leaving FORCE_ON.
- n_on is the popcount of the switch value registered in the same cycle. It updates together with switch.
- g update, each edge:
  - if g_clr: g <= 0.
  - else: g <= min(g + n_on_current, 2^G_W-1), where n_on_current is the registered value before the edge.
  - g_clr takes priority over increment.
  - Saturation holds g at all-ones; it never wraps.
- Undefined mode 11 behaves exactly as AUTO.

Decomposition:
- Shared package: mode constants (MODE_AUTO=2'b00, MODE_FORCE_ON=2'b01, MODE_FORCE_OFF=2'b10), channel state enum (IDLE, ARM, ON, HOLD; 2-bit encoding), clog2 helper.
- One natural sub-module: ssc_channel (single-channel FSM plus counter; params DB_CYC, HOLD_CYC; inputs clk, rst, sensor, auto_en; output sw).
- The top level instantiates N_CH copies with generate and adds the force muxing, popcount and the g accumulator.

Test Plan:
Bench parameters unless noted: N_CH=3, DB_CYC=3, HOLD_CYC=5.
1. Reset: rst=1 for 2 cycles with all sensors high, then release -> switch=0 and g=0 during reset; switch[0] rises exactly 3 edges after release.
2. Debounce: sensor[0] high 2 cycles, low 1, high 3 -> switch[0] stays 0 after the first pulse; it rises on the 3rd high sample of the second pulse.
3. Hold and retrigger: switch[1] on; sensor[1] low 4 cycles, high 1, low 5 -> switch[1] stays 1 throughout the first gap; it falls at the 5th low sample of the second gap.
4. Independence: sensor[0] and sensor[2] rise on the same edge -> both switches rise together, n_on=2, and g grows by 2 per cycle.
5. Modes: in AUTO with switch[1]=1, set FORCE_OFF for 4 cycles then AUTO with sensor[1] still high -> switch=000 next edge; after AUTO, switch[1] returns 3 edges later. FORCE_ON with all sensors low -> switch=111 and n_on=3.
6. Saturation and clear: G_W=4, FORCE_ON for 6 cycles -> g goes 0,3,6,9,12,15,15. Asserting g_clr together with n_on=3 -> g=0 next edge.
